// File: rtl/ack_bus_pkg.sv
// Shared constants, state encoding and helpers for the ACK bus round-robin scheduler.
// HOLD_MAX bounds a single grant and only matters when ACK_ARB_WATCHDOG_EN is defined.
package ack_bus_pkg;

  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned ID_W     = 2;
  localparam int unsigned HOLD_MAX = 15;

  localparam logic [ID_W-1:0] ID_MEM  = 2'd0;
  localparam logic [ID_W-1:0] ID_SHA  = 2'd1;
  localparam logic [ID_W-1:0] ID_AES  = 2'd2;
  localparam logic [ID_W-1:0] ID_CTRL = 2'd3;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StGrant   = 2'd1,
    StRelease = 2'd2
  } state_e;

  function automatic logic [NUM_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
    return NUM_REQ'(1) << id;
  endfunction

endpackage

// File: rtl/ack_rr_pick.sv
// Rotate-priority picker: first set request bit scanning ptr, ptr+1, ... modulo 4.
module ack_rr_pick
  import ack_bus_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               any,
  output logic [ID_W-1:0]    pick
);

  logic [ID_W-1:0] idx;

  always_comb begin
    any  = 1'b0;
    pick = ptr;
    idx  = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + ID_W'(i);
      if (!any && req[idx]) begin
        any  = 1'b1;
        pick = idx;
      end
    end
  end

endmodule

// File: rtl/ack_bus_rr_scheduler.sv
// Registered round-robin grant for the shared ACK bus with one turnaround cycle per release.
// Define ACK_ARB_WATCHDOG_EN to force-release grants held for HOLD_MAX cycles.
module ack_bus_rr_scheduler
  import ack_bus_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    winner_id,
  output logic               ack_event,
  output logic               busy,
  output logic               timeout
);

  state_e          state_q;
  logic [ID_W-1:0] rr_ptr;
  logic            pick_any;
  logic [ID_W-1:0] pick_id;
  logic            owner_req;
  logic            hold_expired;

  ack_rr_pick u_pick (
    .req  (req),
    .ptr  (rr_ptr),
    .any  (pick_any),
    .pick (pick_id)
  );

  assign owner_req = req[winner_id];

`ifdef ACK_ARB_WATCHDOG_EN
  localparam int unsigned CntW = $clog2(HOLD_MAX + 1);

  logic [CntW-1:0] hold_cnt;

  // Counter sits at 0 outside GRANT, so it reads k-1 in the k-th GRANT cycle.
  assign hold_expired = (hold_cnt == CntW'(HOLD_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout  <= (state_q == StGrant) && owner_req && hold_expired;
      hold_cnt <= (state_q == StGrant) ? hold_cnt + CntW'(1) : '0;
    end
  end
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      gnt       <= '0;
      winner_id <= '0;
      ack_event <= 1'b0;
      busy      <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      ack_event <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_any) begin
            gnt       <= id_onehot(pick_id);
            winner_id <= pick_id;
            ack_event <= 1'b1;
            busy      <= 1'b1;
            state_q   <= StGrant;
          end
        end
        StGrant: begin
          if (!owner_req || hold_expired) begin
            gnt     <= '0;
            rr_ptr  <= winner_id + ID_W'(1);
            state_q <= StRelease;
          end
        end
        StRelease: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          gnt     <= '0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ack_bus_rr_scheduler.sv
// Directed self-checking bench for ack_bus_rr_scheduler with hand-computed expectations.
module tb_ack_bus_rr_scheduler;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] winner_id;
  logic       ack_event;
  logic       busy;
  logic       timeout;

  int n_tests;
  int n_fail;

  ack_bus_rr_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .winner_id (winner_id),
    .ack_event (ack_event),
    .busy      (busy),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and settle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] order [5];
  logic [3:0] oh;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    order   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst_n   = 1'b0;
    req     = 4'b0000;
    #12;
    check_eq("rst_gnt", 32'(gnt), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_winner", 32'(winner_id), 32'h0);
    check_eq("rst_ack", 32'(ack_event), 32'h0);
    check_eq("rst_timeout", 32'(timeout), 32'h0);
    rst_n = 1'b1;
    step();
    check_eq("idle_gnt", 32'(gnt), 32'h0);

    // All four requesting: strict rotation MEM, SHA, AES, CTRL, MEM.
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << order[k];
      step();
      check_eq("rr_gnt", 32'(gnt), 32'(oh));
      check_eq("rr_winner", 32'(winner_id), 32'(order[k]));
      check_eq("rr_ack1", 32'(ack_event), 32'h1);
      check_eq("rr_busy", 32'(busy), 32'h1);
      step();
      check_eq("rr_hold", 32'(gnt), 32'(oh));
      check_eq("rr_ack0", 32'(ack_event), 32'h0);
      req = 4'b1111 & ~oh;
      step();
      check_eq("rr_rel_gnt", 32'(gnt), 32'h0);
      check_eq("rr_rel_busy", 32'(busy), 32'h1);
      check_eq("rr_rel_winner", 32'(winner_id), 32'(order[k]));
      req = 4'b1111;
      step();
      check_eq("rr_idle_gnt", 32'(gnt), 32'h0);
      check_eq("rr_idle_busy", 32'(busy), 32'h0);
    end
    // rr_ptr now 1; the IDLE cycle above already saw req=1111, so drain it.
    check_eq("rr_regrant", 32'(gnt), 32'h0);
    req = 4'b0010;
    step();
    check_eq("sha_gnt", 32'(gnt), 32'h2);

    // AES pulse during SHA grant is dropped, not queued.
    req = 4'b0110;
    step();
    check_eq("pulse_hold", 32'(gnt), 32'h2);
    req = 4'b0010;
    step();
    req = 4'b0000;
    step();
    check_eq("pulse_rel", 32'(gnt), 32'h0);
    step();
    step();
    check_eq("pulse_lost", 32'(gnt), 32'h0);
    check_eq("pulse_busy", 32'(busy), 32'h0);

    // CTRL grant then wrap: MEM beats CTRL.
    req = 4'b1000;
    step();
    check_eq("ctrl_gnt", 32'(gnt), 32'h8);
    check_eq("ctrl_winner", 32'(winner_id), 32'h3);
    req = 4'b0000;
    step();
    req = 4'b1001;
    step();
    check_eq("wrap_idle", 32'(gnt), 32'h0);
    step();
    check_eq("wrap_mem", 32'(gnt), 32'h1);
    req = 4'b1000;
    step();
    step();
    check_eq("wrap_idle2", 32'(gnt), 32'h0);
    step();
    check_eq("wrap_ctrl", 32'(gnt), 32'h8);
    req = 4'b0000;
    step();
    step();

    // Asynchronous reset mid-grant.
    req = 4'b0100;
    step();
    check_eq("aes_gnt", 32'(gnt), 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_gnt", 32'(gnt), 32'h0);
    check_eq("arst_busy", 32'(busy), 32'h0);
    check_eq("arst_winner", 32'(winner_id), 32'h0);
    #1;
    rst_n = 1'b1;
    req   = 4'b0110;
    step();
    check_eq("arst_sha_first", 32'(gnt), 32'h2);

    // SHA keeps holding its request.
    req = 4'b0010;
`ifdef ACK_ARB_WATCHDOG_EN
    for (int k = 0; k < 14; k++) begin
      step();
      check_eq("wd_hold", 32'(gnt), 32'h2);
      check_eq("wd_no_to", 32'(timeout), 32'h0);
    end
    req = 4'b0110;
    step();
    check_eq("wd_gnt_drop", 32'(gnt), 32'h0);
    check_eq("wd_timeout", 32'(timeout), 32'h1);
    step();
    check_eq("wd_timeout_pulse", 32'(timeout), 32'h0);
    step();
    check_eq("wd_next_aes", 32'(gnt), 32'h4);
    req = 4'b0000;
    step();
    step();
`else
    for (int k = 0; k < 100; k++) begin
      step();
      check_eq("nowd_hold", 32'(gnt), 32'h2);
      check_eq("nowd_timeout", 32'(timeout), 32'h0);
    end
    req = 4'b0000;
    step();
    step();
`endif

    // Single requester toggling.
    req = 4'b0001;
    step();
    check_eq("tog_gnt", 32'(gnt), 32'h1);
    req = 4'b0000;
    step();
    check_eq("tog_drop", 32'(gnt), 32'h0);
    req = 4'b0001;
    step();
    check_eq("tog_dead", 32'(gnt), 32'h0);
    step();
    check_eq("tog_regrant", 32'(gnt), 32'h1);
    check_eq("tog_ack", 32'(ack_event), 32'h1);
    req = 4'b0000;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
